// File: rtl/pc_gen_if.sv
// Fetch/execute/trap signal bundle for the next-PC generator.
// The generator side uses the master modport; fetch, execute and trap sources use slave.
interface pc_gen_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] fetch_pc;
    logic            fetch_valid;
    logic            fetch_ready;
    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_imm;
    logic [XLEN-1:0] ex_rs1;
    logic            ex_branch_en;
    logic            ex_jal_en;
    logic            ex_jalr_en;
    logic            ex_taken;
    logic [XLEN-1:0] link_addr;
    logic            redirect_en;
    logic            misalign_err;
    logic [XLEN-1:0] misalign_addr;
    logic            trap_en;
    logic [XLEN-1:0] trap_vec;

    modport master (
        output fetch_pc, fetch_valid, link_addr, redirect_en, misalign_err, misalign_addr,
        input  fetch_ready, ex_valid, ex_pc, ex_imm, ex_rs1,
        input  ex_branch_en, ex_jal_en, ex_jalr_en, ex_taken, trap_en, trap_vec
    );

    modport slave (
        input  fetch_pc, fetch_valid, link_addr, redirect_en, misalign_err, misalign_addr,
        output fetch_ready, ex_valid, ex_pc, ex_imm, ex_rs1,
        output ex_branch_en, ex_jal_en, ex_jalr_en, ex_taken, trap_en, trap_vec
    );
endinterface

// File: rtl/pc_gen.sv
// Next-PC generator: resolves execute-stage control flow into a registered fetch PC,
// sequences fetch, flags misaligned targets and waits in HALT for a trap vector.
module pc_gen #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic       clk_i,
    input  logic       reset_i,
    pc_gen_if.master   bus,
    output logic [1:0] state_o
);
    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            valid_q, valid_d;
    logic            redirect_q, redirect_d;
    logic            err_q, err_d;
    logic [XLEN-1:0] err_addr_q, err_addr_d;

    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] target;
    logic            ctrl_event;
    logic [XLEN-1:0] trap_pc;

    assign jalr_sum = bus.ex_rs1 + bus.ex_imm;
    assign trap_pc  = {bus.trap_vec[XLEN-1:2], 2'b00};

    // Class priority branch > jal > jalr: a not-taken branch masks a jal/jalr in the same cycle.
    always_comb begin
        target     = '0;
        ctrl_event = 1'b0;
        if (bus.ex_branch_en) begin
            target     = bus.ex_pc + bus.ex_imm;
            ctrl_event = bus.ex_taken;
        end else if (bus.ex_jal_en) begin
            target     = bus.ex_pc + bus.ex_imm;
            ctrl_event = 1'b1;
        end else if (bus.ex_jalr_en) begin
            target     = {jalr_sum[XLEN-1:1], 1'b0};
            ctrl_event = 1'b1;
        end
        ctrl_event = ctrl_event & bus.ex_valid;
    end

    // Handshake: fetch_pc is transferred in a cycle where fetch_valid & fetch_ready are both high;
    // while fetch_valid & !fetch_ready, fetch_pc holds unless a redirect or trap replaces it.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        redirect_d = 1'b0;
        err_d      = 1'b0;
        err_addr_d = err_addr_q;
        unique case (state_q)
            S_BOOT: state_d = S_RUN;
            S_RUN: begin
                if (bus.trap_en) begin
                    pc_d       = trap_pc;
                    redirect_d = 1'b1;
                end else if (ctrl_event) begin
                    if (target[1:0] == 2'b00) begin
                        pc_d       = target;
                        redirect_d = 1'b1;
                    end else begin
                        err_d      = 1'b1;
                        err_addr_d = target;
                        state_d    = S_HALT;
                    end
                end else if (valid_q && bus.fetch_ready) begin
                    pc_d = pc_q + XLEN'(4);
                end
            end
            S_HALT: begin
                if (bus.trap_en) begin
                    pc_d       = trap_pc;
                    redirect_d = 1'b1;
                    state_d    = S_RUN;
                end
            end
            default: state_d = S_BOOT;
        endcase
        valid_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= S_BOOT;
            pc_q       <= RESET_VECTOR;
            valid_q    <= 1'b0;
            redirect_q <= 1'b0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            redirect_q <= redirect_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign bus.fetch_pc      = pc_q;
    assign bus.fetch_valid   = valid_q;
    assign bus.redirect_en   = redirect_q;
    assign bus.misalign_err  = err_q;
    assign bus.misalign_addr = err_addr_q;
    assign bus.link_addr     = bus.ex_pc + XLEN'(4);
    assign state_o           = state_q;
endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed vectors with literal expectations plus a per-cycle
// comparison against a behavioural next-PC model.
module tb_pc_gen;
    localparam int          XLEN = 32;
    localparam logic [31:0] RV   = 32'h0000_0100;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] state_dbg;
    int         checks   = 0;
    int         failures = 0;
    bit         cmp_en   = 1'b0;

    pc_gen_if #(.XLEN(XLEN)) bus ();

    pc_gen #(.XLEN(XLEN), .RESET_VECTOR(RV)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus),
        .state_o (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_pc, m_addr, m_tgt;
    logic        m_valid, m_redirect, m_err, m_booting, m_halted, m_ev;

    // Which instruction wins, and where it goes.
    always_comb begin
        m_ev  = 1'b0;
        m_tgt = 32'h0;
        if (bus.ex_valid) begin
            if (bus.ex_branch_en) begin
                m_ev  = bus.ex_taken;
                m_tgt = bus.ex_pc + bus.ex_imm;
            end else if (bus.ex_jal_en) begin
                m_ev  = 1'b1;
                m_tgt = bus.ex_pc + bus.ex_imm;
            end else if (bus.ex_jalr_en) begin
                m_ev  = 1'b1;
                m_tgt = (bus.ex_rs1 + bus.ex_imm) - ((bus.ex_rs1 + bus.ex_imm) % 2);
            end
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc <= RV; m_valid <= 1'b0; m_redirect <= 1'b0; m_err <= 1'b0;
            m_addr <= 32'h0; m_booting <= 1'b1; m_halted <= 1'b0;
        end else begin
            m_redirect <= 1'b0;
            m_err      <= 1'b0;
            if (m_booting) begin
                m_booting <= 1'b0;
                m_valid   <= 1'b1;
            end else if (bus.trap_en) begin
                m_pc       <= bus.trap_vec - (bus.trap_vec % 4);
                m_redirect <= 1'b1;
                m_halted   <= 1'b0;
                m_valid    <= 1'b1;
            end else if (!m_halted && m_ev && (m_tgt % 4 == 0)) begin
                m_pc       <= m_tgt;
                m_redirect <= 1'b1;
            end else if (!m_halted && m_ev) begin
                m_err    <= 1'b1;
                m_addr   <= m_tgt;
                m_halted <= 1'b1;
                m_valid  <= 1'b0;
            end else if (!m_halted && m_valid && bus.fetch_ready) begin
                m_pc <= m_pc + 32'd4;
            end
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_fetch_pc",      bus.fetch_pc,              m_pc);
            check("cyc_fetch_valid",   32'(bus.fetch_valid),      32'(m_valid));
            check("cyc_redirect_en",   32'(bus.redirect_en),      32'(m_redirect));
            check("cyc_misalign_err",  32'(bus.misalign_err),     32'(m_err));
            check("cyc_misalign_addr", bus.misalign_addr,         m_addr);
            check("cyc_link_addr",     bus.link_addr,             bus.ex_pc + 32'd4);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ex(input logic br, input logic jal, input logic jalr, input logic taken,
                            input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] rs1);
        bus.ex_valid = 1'b1; bus.ex_branch_en = br; bus.ex_jal_en = jal; bus.ex_jalr_en = jalr;
        bus.ex_taken = taken; bus.ex_pc = pc; bus.ex_imm = imm; bus.ex_rs1 = rs1;
        #1;
    endtask

    task automatic clear_ex();
        bus.ex_valid = 1'b0; bus.ex_branch_en = 1'b0; bus.ex_jal_en = 1'b0;
        bus.ex_jalr_en = 1'b0; bus.ex_taken = 1'b0;
    endtask

    initial begin
        bus.fetch_ready = 1'b1; bus.trap_en = 1'b0; bus.trap_vec = 32'h0;
        bus.ex_pc = 32'h0; bus.ex_imm = 32'h0; bus.ex_rs1 = 32'h0;
        clear_ex();
        #1 rst = 1'b1;
        #1;
        cmp_en = 1'b1;
        check("rst_pc", bus.fetch_pc, RV);
        check("rst_valid", 32'(bus.fetch_valid), 32'h0);
        check("rst_misalign_addr", bus.misalign_addr, 32'h0);
        tick(); tick();
        rst = 1'b0;
        check("boot_valid", 32'(bus.fetch_valid), 32'h0);
        tick();
        check("run_valid", 32'(bus.fetch_valid), 32'h1);
        check("seq_pc0", bus.fetch_pc, 32'h100);
        tick(); check("seq_pc1", bus.fetch_pc, 32'h104);
        tick(); check("seq_pc2", bus.fetch_pc, 32'h108);

        bus.fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); check("stall_hold", bus.fetch_pc, 32'h108);
        end
        bus.fetch_ready = 1'b1;
        tick(); check("stall_resume", bus.fetch_pc, 32'h10C);

        drive_ex(1'b1, 1'b0, 1'b0, 1'b1, 32'h200, 32'hFFFF_FFF0, 32'h0);
        check("br_link", bus.link_addr, 32'h204);
        tick(); check("br_taken_pc", bus.fetch_pc, 32'h1F0);
        check("br_taken_redir", 32'(bus.redirect_en), 32'h1);
        clear_ex();
        tick(); check("br_redir_pulse", 32'(bus.redirect_en), 32'h0);
        check("br_after_pc", bus.fetch_pc, 32'h1F4);
        drive_ex(1'b1, 1'b0, 1'b0, 1'b0, 32'h200, 32'hFFFF_FFF0, 32'h0);
        tick(); check("br_nt_redir", 32'(bus.redirect_en), 32'h0);
        check("br_nt_pc", bus.fetch_pc, 32'h1F8);

        drive_ex(1'b0, 1'b0, 1'b1, 1'b0, 32'h300, 32'h3, 32'h301);
        check("jalr_link", bus.link_addr, 32'h304);
        tick(); check("jalr_pc", bus.fetch_pc, 32'h304);
        clear_ex();
        tick(); check("jalr_next_pc", bus.fetch_pc, 32'h308);
        drive_ex(1'b0, 1'b0, 1'b1, 1'b0, 32'h300, 32'h1, 32'h301);
        tick(); check("mis_err", 32'(bus.misalign_err), 32'h1);
        check("mis_addr", bus.misalign_addr, 32'h302);
        check("mis_valid", 32'(bus.fetch_valid), 32'h0);
        check("mis_pc_hold", bus.fetch_pc, 32'h308);
        drive_ex(1'b0, 1'b1, 1'b0, 1'b0, 32'h300, 32'h100, 32'h0);
        tick(); check("halt_err_pulse", 32'(bus.misalign_err), 32'h0);
        check("halt_ignore_ex", bus.fetch_pc, 32'h308);
        check("halt_addr_held", bus.misalign_addr, 32'h302);
        clear_ex();
        tick(); check("halt_valid", 32'(bus.fetch_valid), 32'h0);
        bus.trap_en = 1'b1; bus.trap_vec = 32'h83;
        tick(); check("trap_pc", bus.fetch_pc, 32'h80);
        check("trap_valid", 32'(bus.fetch_valid), 32'h1);
        check("trap_redir", 32'(bus.redirect_en), 32'h1);

        bus.trap_vec = 32'h80;
        drive_ex(1'b0, 1'b1, 1'b0, 1'b0, 32'h300, 32'h100, 32'h0);
        tick(); check("trap_over_jal", bus.fetch_pc, 32'h80);
        bus.trap_en = 1'b0;
        drive_ex(1'b1, 1'b1, 1'b0, 1'b0, 32'h500, 32'h40, 32'h0);
        tick(); check("br_over_jal_nt_redir", 32'(bus.redirect_en), 32'h0);
        check("br_over_jal_nt_pc", bus.fetch_pc, 32'h84);
        drive_ex(1'b1, 1'b1, 1'b0, 1'b1, 32'h500, 32'h40, 32'h0);
        tick(); check("br_over_jal_t_pc", bus.fetch_pc, 32'h540);

        drive_ex(1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h8, 32'h0);
        check("wrap_link", bus.link_addr, 32'h0);
        tick(); check("wrap_pc", bus.fetch_pc, 32'h4);

        drive_ex(1'b0, 1'b1, 1'b0, 1'b0, 32'h600, 32'h0, 32'h0);
        tick(); check("pre_rst_redir", 32'(bus.redirect_en), 32'h1);
        rst = 1'b1;
        #1;
        check("midrst_pc", bus.fetch_pc, RV);
        check("midrst_redir", 32'(bus.redirect_en), 32'h0);
        check("midrst_valid", 32'(bus.fetch_valid), 32'h0);
        tick(); check("rst_hold_pc", bus.fetch_pc, RV);
        rst = 1'b0;
        clear_ex();
        tick(); tick();
        check("rerun_pc", bus.fetch_pc, 32'h104);
        check("rerun_valid", 32'(bus.fetch_valid), 32'h1);
        tick();

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
